// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall priority, exception flush/redirect,
// plus stall statistics and a consecutive-stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EBASE      = 32'h0000_0020,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout,
    output logic [1:0]  ctrl_state
);

    localparam logic [31:0] ExcEret = 32'h0000_000e;
    localparam logic [15:0] WdogMax = 16'(WDOG_LIMIT);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wdog_q, wdog_d;
    logic [31:0] stall_cycles_q;
    logic        stall_timeout_q;
    logic        exc;

    assign exc = (excepttype_i != 32'h0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls through to RUN
    always_comb begin
        state_d = StRun;
        case (state_q)
            StRun, StStall: begin
                if (flush) begin
                    state_d = StFlush;
                end else if (stall != 6'b000000) begin
                    state_d = StStall;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: state_d = flush ? StFlush : StRun;
            default: state_d = StRun;
        endcase
    end

    // Output logic; FLUSH is a bubble-recovery cycle, so stall requests are ignored there
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (!rst) begin
            case (state_q)
                StRun, StStall: begin
                    if (exc) begin
                        flush = 1'b1;
                    end else if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end
                end
                StFlush: flush = exc;
                default: ;
            endcase
            if (flush) begin
                new_pc = (excepttype_i == ExcEret) ? cp0_epc_i : EBASE;
            end
        end
    end

    always_comb begin
        wdog_d = wdog_q;
        if (flush || stall == 6'b000000) begin
            wdog_d = 16'h0;
        end else if (wdog_q != WdogMax) begin
            wdog_d = wdog_q + 16'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q          <= 16'h0;
            stall_cycles_q  <= 32'h0;
            stall_timeout_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (stall != 6'b000000 && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'h1;
            end
            if (wdog_d == WdogMax) begin
                stall_timeout_q <= 1'b1;
            end
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign stall_timeout = stall_timeout_q;
    assign ctrl_state    = state_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter EBASE, default 32'h0000_0020, meaning exception entry address.
REQ-002 The block SHALL have parameter WDOG_LIMIT, default 255, meaning consecutive-stall cycles before timeout (range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high (`RstEnable`).
REQ-005 The block SHALL have port stallreq_id, input, 1 bit: decode stage requests stall (load-use).
REQ-006 The block SHALL have port stallreq_ex, input, 1 bit: execute stage requests stall (multi-cycle op).
REQ-007 The block SHALL have port stallreq_mem, input, 1 bit: memory stage requests stall (bus wait).
REQ-008 The block SHALL have port excepttype_i, input, 32 bits: nonzero means an exception at the mem stage; 32'h0000_000e means eret.
REQ-009 The block SHALL have port cp0_epc_i, input, 32 bits: EPC value for eret return.
REQ-010 The block SHALL have port stall, output, 6 bits: hold vector; bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb.
REQ-011 The block SHALL have port flush, output, 1 bit: clear all pipeline registers this cycle.
REQ-012 The block SHALL have port new_pc, output, 32 bits: redirect target, valid when flush=1.
REQ-013 The block SHALL have port stall_cycles, output, 32 bits: saturating count of cycles with stall!=0.
REQ-014 The block SHALL have port stall_timeout, output, 1 bit: sticky watchdog flag.
REQ-015 The block SHALL have port ctrl_state, output, 2 bits: current FSM state.

Function
REQ-016 stall, flush and new_pc SHALL be combinational from the inputs and current state, taking effect in the same cycle; stall_cycles, stall_timeout and ctrl_state SHALL be registered.
REQ-017 FSM states SHALL be RUN=2'b00, STALL=2'b01, FLUSH=2'b10; 2'b11 is illegal and SHALL recover to RUN on the next clock.
REQ-018 In RUN or STALL with excepttype_i!=0: flush=1, stall=6'b000000, next state FLUSH; exception beats every stall request.
REQ-019 In RUN or STALL with excepttype_i==0, stall priority SHALL be mem > ex > id.
REQ-020 Stall vectors SHALL be: stallreq_mem gives 6'b011111, else stallreq_ex gives 6'b001111, else stallreq_id gives 6'b000111, else 6'b000000.
REQ-021 If stall!=0, next state SHALL be STALL, else RUN.
REQ-022 new_pc SHALL be cp0_epc_i when excepttype_i==32'h0000_000e, EBASE for any other nonzero excepttype_i, and 32'h0 when flush=0.
REQ-023 In FLUSH, all stall requests SHALL be ignored (stall=0, flush=0) and next state SHALL be RUN; this is the recovery cycle for flushed bubbles.
REQ-024 In FLUSH, excepttype_i!=0 SHALL still be accepted (flush=1, new_pc per REQ-022), and the state SHALL stay FLUSH.
REQ-025 A 16-bit consecutive-stall counter SHALL increment each cycle with stall!=0, clear to 0 on any cycle with stall==0 or flush=1, and saturate at WDOG_LIMIT.
REQ-026 On the clock edge where the counter reaches WDOG_LIMIT, stall_timeout SHALL set to 1 and hold until rst.
REQ-027 stall_cycles SHALL increment by 1 on each cycle with stall!=0 and saturate at 32'hFFFF_FFFF with no wrap.
REQ-028 stall_timeout SHALL NOT force stall, flush or redirect; it is status only.

Reset
REQ-029 While rst=1 at a clock edge, the next state SHALL be RUN, ctrl_state=2'b00, stall_cycles=0, stall_timeout=0 and the consecutive counter=0.
REQ-030 During any cycle with rst=1, stall=6'b000000, flush=0 and new_pc=32'h0 regardless of inputs.
REQ-031 rst asserted in STALL or FLUSH SHALL abort the operation with no residual flush or stall after reset release.

Verification
REQ-032 Scenario: stallreq_id=1 for 1 cycle from RUN -> stall=6'b000111 that cycle, ctrl_state=01 next cycle then 00, stall_cycles=1.
REQ-033 Scenario: stallreq_id=stallreq_ex=stallreq_mem=1 together -> stall=6'b011111; drop mem only -> 6'b001111.
REQ-034 Scenario: excepttype_i=32'h0000_0008 with stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h0000_0020; next cycle with stallreq_ex=1 (FLUSH) -> stall=0, flush=0; then RUN.
REQ-035 Scenario: excepttype_i=32'h0000_000e, cp0_epc_i=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234.
REQ-036 Scenario: WDOG_LIMIT=4, stallreq_ex held for 6 cycles -> stall_timeout rises after the 4th stalled edge and stays 1 after the requests drop; stall_cycles=6; cleared only by rst.
REQ-037 Scenario: rst=1 in mid-STALL with stallreq_mem=1 -> stall=0 in that cycle; after release ctrl_state=00, stall_cycles=0, stall_timeout=0.
